// File: rtl/vga_fb_write_ctrl.sv
// -----------------------------------------------------------------------------
// vga_fb_write_ctrl
//
// Owns the write port of the dual-port VGA frame buffer (the signal generator
// owns the read port). Frame-buffer writes come from two requesters:
//   - single-pixel writes issued over the processor bus, and
//   - a hardware fill engine that clears or sets the whole image.
// A pixel write always wins. The fill engine then holds its counters for that
// cycle, so no address is skipped. The block also holds the 16-bit
// foreground/background colour register that feeds the signal generator.
//
// Build option:
//   VGA_FB_FILL_EN  defined   -> fill engine (IDLE/FILL FSM + counters) present
//                   undefined -> no fill hardware; start writes are accepted and
//                                ignored, FILL_BUSY/FILL_DONE tied 0
//
// Register map (offsets from BASE_ADDR):
//   +0 X[7:0]   +1 Y[6:0]   +2 pixel write (data bit0, reads 0)
//   +3 CONFIG_COLOURS[7:0]  +4 CONFIG_COLOURS[15:8]
//   +5 fill start (bit0 start, bit1 value), reads {7'b0, FILL_BUSY}
//
// Ports:
//   CLK, RESET          system clock, asynchronous active-high reset
//   BUS_ADDR/DATA_IN/WE processor bus request (WE=0 on a decoded address = read)
//   BUS_DATA_OUT/OE     registered read data and its one-cycle drive enable
//   FB_WE/ADDR/DATA     frame-buffer write port, ADDR = {Y[6:0], X[7:0]}
//   CONFIG_COLOURS      colour register
//   FILL_BUSY/FILL_DONE fill engine active / one-cycle completion pulse
// -----------------------------------------------------------------------------
module vga_fb_write_ctrl #(
   parameter logic [7:0]  BASE_ADDR  = 8'hB0,
   parameter int          X_PIXELS   = 160,
   parameter int          Y_PIXELS   = 120,
   parameter logic [15:0] COLOUR_RST = 16'hFF00
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  BUS_ADDR,
   input  logic [7:0]  BUS_DATA_IN,
   input  logic        BUS_WE,
   output logic [7:0]  BUS_DATA_OUT,
   output logic        BUS_DATA_OE,
   output logic        FB_WE,
   output logic [14:0] FB_ADDR,
   output logic        FB_DATA,
   output logic [15:0] CONFIG_COLOURS,
   output logic        FILL_BUSY,
   output logic        FILL_DONE
);

   localparam logic [7:0] X_LIM  = 8'(X_PIXELS);
   localparam logic [6:0] Y_LIM  = 7'(Y_PIXELS);
   localparam logic [7:0] X_LAST = 8'(X_PIXELS - 1);
   localparam logic [6:0] Y_LAST = 7'(Y_PIXELS - 1);

   // Offset wraps modulo 256, so a single unsigned compare decodes the window.
   logic [7:0]  offset;
   logic        decoded;
   logic        wr_x, wr_y, wr_pix, wr_col_lo, wr_col_hi;
   logic        rd_req;

   assign offset    = BUS_ADDR - BASE_ADDR;
   assign decoded   = (offset < 8'd6);
   assign wr_x      = decoded && BUS_WE && (offset == 8'd0);
   assign wr_y      = decoded && BUS_WE && (offset == 8'd1);
   assign wr_pix    = decoded && BUS_WE && (offset == 8'd2);
   assign wr_col_lo = decoded && BUS_WE && (offset == 8'd3);
   assign wr_col_hi = decoded && BUS_WE && (offset == 8'd4);
   assign rd_req    = decoded && !BUS_WE;

   logic [7:0]  x_reg;
   logic [6:0]  y_reg;
   logic        on_screen;

   assign on_screen = (x_reg < X_LIM) && (y_reg < Y_LIM);

   // Fill engine signals, driven by whichever build variant is selected.
   logic        fill_busy;
   logic        fill_wr;
   logic        fill_done;
   logic        fill_val;
   logic [14:0] fill_addr;

   // Pixel-write stage p0: request registered with the coordinates held before the edge
   logic        pix_vld_p0;
   logic [14:0] pix_addr_p0;
   logic        pix_data_p0;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         x_reg          <= '0;
         y_reg          <= '0;
         CONFIG_COLOURS <= COLOUR_RST;
         pix_vld_p0     <= 1'b0;
         pix_addr_p0    <= '0;
         pix_data_p0    <= 1'b0;
      end else begin
         if (wr_x)      x_reg                <= BUS_DATA_IN;
         if (wr_y)      y_reg                <= BUS_DATA_IN[6:0];
         if (wr_col_lo) CONFIG_COLOURS[7:0]  <= BUS_DATA_IN;
         if (wr_col_hi) CONFIG_COLOURS[15:8] <= BUS_DATA_IN;
         // Off-screen requests are dropped here and never reach the frame buffer.
         pix_vld_p0 <= wr_pix && on_screen;
         if (wr_pix) begin
            pix_addr_p0 <= {y_reg, x_reg};
            pix_data_p0 <= BUS_DATA_IN[0];
         end
      end
   end

`ifdef VGA_FB_FILL_EN
   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  fx;
   logic [6:0]  fy;
   logic        fill_last;
   logic        fill_start;
   logic        fill_val_r;
   logic        fill_done_r;

   assign fill_start = decoded && BUS_WE && (offset == 8'd5) && BUS_DATA_IN[0];
   assign fill_last  = (fx == X_LAST) && (fy == Y_LAST);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Start writes while already filling are ignored; leaving FILL needs the
   // last address to have actually been written (not stalled by a pixel write).
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (fill_start)           state_nxt = S_FILL;
         S_FILL: if (fill_wr && fill_last) state_nxt = S_IDLE;
         default:                          state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      fill_busy = (state == S_FILL);
      fill_wr   = (state == S_FILL) && !pix_vld_p0;
   end

   // Fill counters advance only on cycles where the fill owns the write port
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         fx          <= '0;
         fy          <= '0;
         fill_val_r  <= 1'b0;
         fill_done_r <= 1'b0;
      end else begin
         fill_done_r <= fill_wr && fill_last;
         if ((state == S_IDLE) && fill_start) begin
            fx         <= '0;
            fy         <= '0;
            fill_val_r <= BUS_DATA_IN[1];
         end else if (fill_wr) begin
            if (fx == X_LAST) begin
               fx <= '0;
               fy <= fill_last ? 7'd0 : fy + 7'd1;
            end else begin
               fx <= fx + 8'd1;
            end
         end
      end
   end

   assign fill_val  = fill_val_r;
   assign fill_done = fill_done_r;
   assign fill_addr = {fy, fx};
`else
   assign fill_busy = 1'b0;
   assign fill_wr   = 1'b0;
   assign fill_done = 1'b0;
   assign fill_val  = 1'b0;
   assign fill_addr = '0;
`endif

   // Write-port mux: pixel write has priority; port reads as zero when idle.
   assign FB_WE     = pix_vld_p0 | fill_wr;
   assign FB_ADDR   = pix_vld_p0 ? pix_addr_p0 : (fill_wr ? fill_addr : 15'd0);
   assign FB_DATA   = pix_vld_p0 ? pix_data_p0 : (fill_wr & fill_val);
   assign FILL_BUSY = fill_busy;
   assign FILL_DONE = fill_done;

   logic [7:0] rd_data;

   always_comb begin
      rd_data = 8'h00;
      case (offset)
         8'd0:    rd_data = x_reg;
         8'd1:    rd_data = {1'b0, y_reg};
         8'd3:    rd_data = CONFIG_COLOURS[7:0];
         8'd4:    rd_data = CONFIG_COLOURS[15:8];
         8'd5:    rd_data = {7'b0, fill_busy};
         default: rd_data = 8'h00;
      endcase
   end

   // Read stage p0: data and drive enable presented the cycle after the request
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         BUS_DATA_OE  <= 1'b0;
         BUS_DATA_OUT <= 8'h00;
      end else begin
         BUS_DATA_OE  <= rd_req;
         BUS_DATA_OUT <= rd_req ? rd_data : 8'h00;
      end
   end

endmodule

// File: tb/tb_vga_fb_write_ctrl.sv
module tb_vga_fb_write_ctrl;

   localparam int X_PIX = 160;
   localparam int Y_PIX = 120;

   logic        CLK;
   logic        RESET;
   logic [7:0]  BUS_ADDR;
   logic [7:0]  BUS_DATA_IN;
   logic        BUS_WE;
   logic [7:0]  BUS_DATA_OUT;
   logic        BUS_DATA_OE;
   logic        FB_WE;
   logic [14:0] FB_ADDR;
   logic        FB_DATA;
   logic [15:0] CONFIG_COLOURS;
   logic        FILL_BUSY;
   logic        FILL_DONE;

   vga_fb_write_ctrl dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .BUS_ADDR       (BUS_ADDR),
      .BUS_DATA_IN    (BUS_DATA_IN),
      .BUS_WE         (BUS_WE),
      .BUS_DATA_OUT   (BUS_DATA_OUT),
      .BUS_DATA_OE    (BUS_DATA_OE),
      .FB_WE          (FB_WE),
      .FB_ADDR        (FB_ADDR),
      .FB_DATA        (FB_DATA),
      .CONFIG_COLOURS (CONFIG_COLOURS),
      .FILL_BUSY      (FILL_BUSY),
      .FILL_DONE      (FILL_DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act !== req) $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      else             n_pass++;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic w);
      BUS_ADDR    = a;
      BUS_DATA_IN = d;
      BUS_WE      = w;
   endtask

   task automatic idle();
      drive(8'h00, 8'h00, 1'b0);
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Raster position of the k-th fill write.
   function automatic logic [14:0] exp_addr(input int k);
      int row;
      int col;
      row = k / X_PIX;
      col = k % X_PIX;
      return {row[6:0], col[7:0]};
   endfunction

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  data;
      logic        we;
      logic        oe;
      logic [7:0]  dout;
      logic        fbwe;
      logic [14:0] fbaddr;
      logic        fbdata;
      logic [15:0] col;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic [7:0] a, input logic [7:0] d, input logic w,
                      input logic oe, input logic [7:0] dout, input logic fw,
                      input logic [14:0] fa, input logic fd, input logic [15:0] c);
      vec_t v;
      v = '{a, d, w, oe, dout, fw, fa, fd, c};
      tv.push_back(v);
   endtask

`ifdef VGA_FB_FILL_EN
   task automatic run_fill(input logic [7:0] sd, input bit ev,
                           output int nwr, output int nbusy, output int nerr,
                           output bit done_seen, output logic [14:0] first_a,
                           output logic [14:0] last_a);
      bit   pix_due;
      bit   rd_due;
      bit   col_due;
      logic fv;
      fv = sd[1];
      nwr = 0; nbusy = 0; nerr = 0; done_seen = 0;
      pix_due = 0; rd_due = 0; col_due = 0;
      first_a = '1; last_a = '1;
      drive(8'hB5, sd, 1'b1);
      tick();
      chk("fill_busy_start", FILL_BUSY, 32'd1);
      for (int c = 0; c < 20500; c++) begin
         if (FILL_DONE) begin
            done_seen = 1;
            break;
         end
         if (FILL_BUSY) nbusy++;
         if (pix_due) begin
            chk("fill_pix_we", FB_WE, 32'd1);
            chk("fill_pix_addr", FB_ADDR, 32'h0A0A);
            chk("fill_pix_data", FB_DATA, 32'd0);
            pix_due = 0;
         end else if (FB_WE) begin
            if (FB_ADDR !== exp_addr(nwr) || FB_DATA !== fv) nerr++;
            if (nwr == 0) first_a = FB_ADDR;
            last_a = FB_ADDR;
            nwr++;
         end else if (FILL_BUSY) begin
            nerr++;
         end
         if (rd_due) begin
            chk("fill_rd_oe", BUS_DATA_OE, 32'd1);
            chk("fill_rd_busy", BUS_DATA_OUT, 32'h01);
            rd_due = 0;
         end
         if (col_due) begin
            chk("fill_col_lo", CONFIG_COLOURS[7:0], 32'h55);
            col_due = 0;
         end
         idle();
         if (c == 50) begin
            drive(8'hB5, 8'h00, 1'b0);
            rd_due = 1;
         end
         if (ev) begin
            if (c == 300) begin
               drive(8'hB2, 8'h00, 1'b1);
               pix_due = 1;
            end
            if (c == 500) drive(8'hB5, 8'h03, 1'b1);
            if (c == 700) begin
               drive(8'hB3, 8'h55, 1'b1);
               col_due = 1;
            end
            if (c == 800) drive(8'hB0, 8'h01, 1'b1);
         end
         tick();
      end
   endtask
`endif

   logic [7:0]  m_x;
   logic [6:0]  m_y;
   logic [15:0] m_col;
   logic [7:0]  ra, rd, roff;
   logic        rw;
   logic        e_we, e_data, e_oe;
   logic [14:0] e_addr;
   logic [7:0]  e_dout;
   int          op;
   int          cnt;

   initial begin
      RESET = 1'b0;
      idle();
      #2 RESET = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_fb_we", FB_WE, 32'd0);
      chk("rst_fb_addr", FB_ADDR, 32'd0);
      chk("rst_fb_data", FB_DATA, 32'd0);
      chk("rst_oe", BUS_DATA_OE, 32'd0);
      chk("rst_dout", BUS_DATA_OUT, 32'd0);
      chk("rst_colours", CONFIG_COLOURS, 32'hFF00);
      chk("rst_busy", FILL_BUSY, 32'd0);
      chk("rst_done", FILL_DONE, 32'd0);
      RESET = 1'b0;

      //   addr   data   we    oe    dout   fbwe  fbaddr     fbd   colours
      add(8'hB0, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'hFF00);
      add(8'hB1, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'hFF00);
      add(8'hB2, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 15'h0305, 1'b1, 16'hFF00);
      add(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'hFF00);
      add(8'hB0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0, 15'h0000, 1'b0, 16'hFF00);
      add(8'hB1, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 15'h0000, 1'b0, 16'hFF00);
      add(8'hB2, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 15'h0000, 1'b0, 16'hFF00);
      add(8'hB3, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'hFF12);
      add(8'hB4, 8'h34, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB3, 8'h00, 1'b0, 1'b1, 8'h12, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB4, 8'h00, 1'b0, 1'b1, 8'h34, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB1, 8'h83, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB1, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB0, 8'hA0, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB2, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB0, 8'h00, 1'b0, 1'b1, 8'hA0, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB0, 8'h9F, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB2, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 15'h779F, 1'b0, 16'h3412);
      add(8'hB2, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 15'h779F, 1'b1, 16'h3412);
      add(8'hB1, 8'h78, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB2, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB6, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hAF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);
      add(8'hB5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 15'h0000, 1'b0, 16'h3412);

      @(negedge CLK);
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].addr, tv[i].data, tv[i].we);
         tick();
         chk($sformatf("vec%0d_oe", i), BUS_DATA_OE, 32'(tv[i].oe));
         chk($sformatf("vec%0d_dout", i), BUS_DATA_OUT, 32'(tv[i].dout));
         chk($sformatf("vec%0d_fbwe", i), FB_WE, 32'(tv[i].fbwe));
         if (tv[i].fbwe) begin
            chk($sformatf("vec%0d_fbaddr", i), FB_ADDR, 32'(tv[i].fbaddr));
            chk($sformatf("vec%0d_fbdata", i), FB_DATA, 32'(tv[i].fbdata));
         end
         chk($sformatf("vec%0d_col", i), CONFIG_COLOURS, 32'(tv[i].col));
      end

      // Asynchronous reset in the middle of a cycle with a pixel write on the port.
      drive(8'hB1, 8'h05, 1'b1);
      tick();
      drive(8'hB2, 8'h01, 1'b1);
      tick();
      chk("pre_rst_we", FB_WE, 32'd1);
      chk("pre_rst_addr", FB_ADDR, 32'h059F);
      idle();
      #2 RESET = 1'b1;
      #1;
      chk("arst_fb_we", FB_WE, 32'd0);
      chk("arst_fb_addr", FB_ADDR, 32'd0);
      chk("arst_fb_data", FB_DATA, 32'd0);
      chk("arst_colours", CONFIG_COLOURS, 32'hFF00);
      chk("arst_busy", FILL_BUSY, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      drive(8'hB0, 8'h00, 1'b0);
      tick();
      chk("arst_x_oe", BUS_DATA_OE, 32'd1);
      chk("arst_x_val", BUS_DATA_OUT, 32'd0);

      // Random bus traffic against a register-level model of the block.
      m_x = 8'h00; m_y = 7'h00; m_col = 16'hFF00;
      for (int i = 0; i < 1500; i++) begin
         op = $urandom_range(0, 8);
         rd = 8'($urandom);
         rw = 1'b1;
         ra = 8'h00;
         e_we = 1'b0; e_addr = 15'h0; e_data = 1'b0; e_oe = 1'b0; e_dout = 8'h00;
         case (op)
            0: begin ra = 8'hB0; rd = 8'($urandom_range(0, 175)); m_x = rd; end
            1: begin ra = 8'hB1; m_y = rd[6:0]; end
            2, 3: begin
               ra = 8'hB2;
               e_we = (int'(m_x) < X_PIX) && (int'(m_y) < Y_PIX);
               e_addr = {m_y, m_x};
               e_data = rd[0];
            end
            4: begin ra = 8'hB3; m_col[7:0] = rd; end
            5: begin ra = 8'hB4; m_col[15:8] = rd; end
            6, 7: begin
               rw = 1'b0;
               roff = 8'($urandom_range(0, 5));
               ra = 8'hB0 + roff;
               e_oe = 1'b1;
               case (roff)
                  8'd0:    e_dout = m_x;
                  8'd1:    e_dout = {1'b0, m_y};
                  8'd3:    e_dout = m_col[7:0];
                  8'd4:    e_dout = m_col[15:8];
                  default: e_dout = 8'h00;
               endcase
            end
            default: begin
               rw = $urandom_range(0, 1) == 1;
               ra = 8'($urandom);
               while (ra >= 8'hB0 && ra <= 8'hB5) ra = 8'($urandom);
            end
         endcase
         drive(ra, rd, rw);
         tick();
         chk("rnd_fb_we", FB_WE, 32'(e_we));
         if (e_we) begin
            chk("rnd_fb_addr", FB_ADDR, 32'(e_addr));
            chk("rnd_fb_data", FB_DATA, 32'(e_data));
         end
         chk("rnd_oe", BUS_DATA_OE, 32'(e_oe));
         chk("rnd_dout", BUS_DATA_OUT, 32'(e_dout));
         chk("rnd_col", CONFIG_COLOURS, 32'(m_col));
      end
      idle();
      tick();

`ifdef VGA_FB_FILL_EN
      begin
         int          nwr, nbusy, nerr;
         bit          dn;
         logic [14:0] fa, la;

         run_fill(8'h03, 1'b0, nwr, nbusy, nerr, dn, fa, la);
         chk("fill1_done_seen", 32'(dn), 32'd1);
         chk("fill1_busy_after", FILL_BUSY, 32'd0);
         chk("fill1_writes", nwr, 32'd19200);
         chk("fill1_cycles", nbusy, 32'd19200);
         chk("fill1_seq_errs", nerr, 32'd0);
         chk("fill1_first", fa, 32'h0000);
         chk("fill1_last", la, 32'h779F);
         idle();
         tick();
         chk("fill1_done_pulse", FILL_DONE, 32'd0);

         drive(8'hB0, 8'h0A, 1'b1);
         tick();
         drive(8'hB1, 8'h0A, 1'b1);
         tick();
         run_fill(8'h01, 1'b1, nwr, nbusy, nerr, dn, fa, la);
         chk("fill2_done_seen", 32'(dn), 32'd1);
         chk("fill2_writes", nwr, 32'd19200);
         chk("fill2_cycles", nbusy, 32'd19201);
         chk("fill2_seq_errs", nerr, 32'd0);
         chk("fill2_last", la, 32'h779F);
         idle();
         tick();
         chk("fill2_done_pulse", FILL_DONE, 32'd0);

         drive(8'hB5, 8'h03, 1'b1);
         tick();
         idle();
         cnt = 0;
         for (int c = 0; c < 3000; c++) begin
            if (FB_WE) cnt++;
            if (cnt == 1000) break;
            tick();
         end
         chk("abort_reached", cnt, 32'd1000);
         #2 RESET = 1'b1;
         #1;
         chk("abort_busy", FILL_BUSY, 32'd0);
         chk("abort_fb_we", FB_WE, 32'd0);
         chk("abort_done", FILL_DONE, 32'd0);
         @(negedge CLK);
         RESET = 1'b0;
         cnt = 0;
         for (int c = 0; c < 30; c++) begin
            tick();
            if (FILL_DONE || FILL_BUSY || FB_WE) cnt++;
         end
         chk("abort_quiet", cnt, 32'd0);
      end
`else
      drive(8'hB5, 8'h03, 1'b1);
      tick();
      idle();
      chk("nofill_busy", FILL_BUSY, 32'd0);
      chk("nofill_we", FB_WE, 32'd0);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (FILL_DONE || FILL_BUSY || FB_WE) cnt++;
      end
      chk("nofill_quiet", cnt, 32'd0);
      drive(8'hB5, 8'h00, 1'b0);
      tick();
      chk("nofill_rd_oe", BUS_DATA_OE, 32'd1);
      chk("nofill_rd_val", BUS_DATA_OUT, 32'd0);
      idle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/vga_fb_write_ctrl.md
Name: vga_fb_write_ctrl

Overview:
- Bus-mapped controller that owns the write port of the dual-port VGA frame buffer.
- The VGA signal generator owns the read port.
- Arbitrates frame-buffer writes between two requesters:
  - single-pixel writes from the processor bus;
  - a hardware fill engine that clears or sets the whole 160x120 image.
- Holds the 16-bit foreground/background colour register that drives the signal generator's CONFIG_COLOURS.

Parameters:
BASE_ADDR, 8'hB0, bus base address; the block decodes BASE_ADDR+0 .. BASE_ADDR+5
X_PIXELS, 160, visible pixel columns; X coordinates >= X_PIXELS are off-screen
Y_PIXELS, 120, visible pixel rows; Y coordinates >= Y_PIXELS are off-screen
COLOUR_RST, 16'hFF00, reset value of the colour register

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
BUS_ADDR  in  8  processor bus address
BUS_DATA_IN  in  8  processor write data
BUS_WE  in  1  bus write strobe; BUS_WE=0 with a decoded address is a read
BUS_DATA_OUT  out  8  registered read data
BUS_DATA_OE  out  1  read-data valid/drive enable, one cycle
FB_WE  out  1  frame-buffer write enable
FB_ADDR  out  15  frame-buffer write address {Y[6:0], X[7:0]}
FB_DATA  out  1  frame-buffer write data (pixel on/off)
CONFIG_COLOURS  out  16  colour register, fed to the signal generator
FILL_BUSY  out  1  fill engine active
FILL_DONE  out  1  one-cycle pulse when a fill completes

Behaviour:
- Reset values (async RESET): all outputs 0, except CONFIG_COLOURS=COLOUR_RST. X=0, Y=0, state IDLE.
- Register map, writes taken at the posedge where BUS_WE=1:
  - +0: X[7:0].
  - +1: Y[6:0]; bit 7 ignored.
  - +2: pixel write request; data = BUS_DATA_IN[0].
  - +3: CONFIG_COLOURS[7:0].
  - +4: CONFIG_COLOURS[15:8].
  - +5: fill start; bit0=1 starts, bit1 = fill value.
- Reads, at the posedge where BUS_WE=0 and the address decodes:
  - Next cycle: BUS_DATA_OE=1, BUS_DATA_OUT = register value.
  - +2 reads 0. +5 reads {7'b0, FILL_BUSY}.
  - Undecoded address: BUS_DATA_OE=0, BUS_DATA_OUT=0.
- Pixel write:
  - Request at posedge N -> FB_WE=1 during cycle N+1 with FB_ADDR={Y,X} (values registered before edge N) and FB_DATA=bit0.
  - If X>=X_PIXELS or Y>=Y_PIXELS, the request is dropped: no FB_WE.
  - FB_WE is a single-cycle strobe.
- Fill engine states: IDLE, FILL.
  - IDLE -> FILL on a start write. Fill counters are cleared to (0,0) and the fill value is latched. FILL_BUSY=1 from cycle N+1.
  - In FILL, each cycle without a competing pixel write:
    - FB_WE=1, FB_ADDR={fy,fx}, FB_DATA = fill value.
    - fx increments; at fx=X_PIXELS-1, fx wraps to 0 and fy increments.
  - Last write is at (X_PIXELS-1, Y_PIXELS-1). On the next cycle: state IDLE, FILL_BUSY=0, FILL_DONE=1 for one cycle.
  - An unstalled fill takes exactly X_PIXELS*Y_PIXELS = 19200 write cycles.
- Arbitration:
  - A pixel write has priority over the fill engine.
  - In a cycle where a pixel write is granted, the fill engine does not write and holds its counters; no address is skipped.
  - Each stall lengthens the fill by one cycle.
- Simultaneous or edge cases:
  - A start write while FILL is active is ignored; the fill continues unchanged.
  - A colour write during FILL takes effect immediately.
  - X/Y writes during FILL affect only pixel writes.
  - RESET mid-fill aborts the fill. Outputs go to reset values. No FILL_DONE pulse.
- Width rules:
  - FB_ADDR is always exactly {Y[6:0], X[7:0]}.
  - Counters fx (8-bit) and fy (7-bit) never exceed X_PIXELS-1 and Y_PIXELS-1.

Optional Feature:
- Macro: VGA_FB_FILL_EN.
- Defined: the fill engine is present as specified above.
- Undefined:
  - No fill state machine or counters are built.
  - A start write to +5 is accepted and ignored.
  - FILL_BUSY and FILL_DONE are tied 0; a read of +5 returns 0.
  - FB_WE is driven only by pixel writes.

Test Plan:
- RESET pulse asynchronously mid-cycle -> all outputs 0 immediately, CONFIG_COLOURS=16'hFF00.
- Write X=5, Y=3, then +2 with 8'h01 -> one cycle later FB_WE=1, FB_ADDR=15'h0305, FB_DATA=1; FB_WE=0 the cycle after.
- Write X=160 (8'hA0), then a pixel write -> FB_WE never asserts.
- Start fill with 8'h03 (value 1) -> FILL_BUSY=1; 19200 consecutive FB_WE writes, the first to 15'h0000 and the last to 15'h779F; then FILL_DONE pulses once and FILL_BUSY=0.
- During fill, issue a pixel write at (10,10) with data 0 -> that cycle FB_ADDR=15'h0A0A, FB_DATA=0; the fill resumes at the held address with no gap; total fill duration is 19201 cycles.
- During fill, read +5 -> BUS_DATA_OE=1, BUS_DATA_OUT=8'h01. Assert RESET at fill write 1000 -> FILL_BUSY=0, no FILL_DONE pulse, FB_WE=0.
